// File: rtl/alu_share_arbiter.sv
// Shares one external negedge-sampled ALU between two valid/ready requesters and returns result/zero with the owner id.
// Define ALU_ARB_FIXED_PRIO_EN to make req0 win every tie (req1 may starve); default build is round-robin.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_in1,
  input  logic [DATA_W-1:0] req0_in2,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_in1,
  input  logic [DATA_W-1:0] req1_in2,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  // state  | meaning
  // IDLE   | offering ready to the granted requester
  // ISSUE  | alu_* driven for one full cycle, ALU samples on the negedge
  // RESP   | captured result held until the consumer takes it
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                rr_last_q, rr_last_d;
  logic                id_q, id_d;
  logic [DATA_W-1:0]   in1_q, in1_d;
  logic [DATA_W-1:0]   in2_q, in2_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                zero_q, zero_d;
  logic                gnt_id;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= S_IDLE;
      rr_last_q <= 1'b1;
      id_q      <= 1'b0;
      in1_q     <= '0;
      in2_q     <= '0;
      ctrl_q    <= '0;
      res_q     <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      id_q      <= id_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      ctrl_q    <= ctrl_d;
      res_q     <= res_d;
      zero_q    <= zero_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    id_d       = id_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    ctrl_d     = ctrl_q;
    res_d      = res_q;
    zero_d     = zero_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    gnt_id = ~req0_valid;
`else
    // on a tie the requester that did not win last time goes next
    gnt_id = (req0_valid & req1_valid) ? ~rr_last_q : ~req0_valid;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0_valid | req1_valid) begin
          req0_ready = ~gnt_id;
          req1_ready = gnt_id;
          id_d       = gnt_id;
          rr_last_d  = gnt_id;
          in1_d      = gnt_id ? req1_in1  : req0_in1;
          in2_d      = gnt_id ? req1_in2  : req0_in2;
          ctrl_d     = gnt_id ? req1_ctrl : req0_ctrl;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        res_d   = alu_result;
        zero_d  = alu_zero;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // ready must read low while reset is held even if a requester is valid
    if (!Rst_n) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  assign rsp_valid  = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign alu_in1    = in1_q;
  assign alu_in2    = in2_q;
  assign alu_ctrl   = ctrl_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: vector table, directed corner sequences, and a randomized run
// checked by a transaction-level scoreboard with its own ALU model.
module tb_alu_share_arbiter;

  logic        Clk, Rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
  logic [31:0] rsp_result, alu_in1, alu_in2;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result = '0;
  logic        alu_zero = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  alu_share_arbiter #(.DATA_W(32), .CTRL_W(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1),
    .req0_in2(req0_in2), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1),
    .req1_in2(req1_in2), .req1_ctrl(req1_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return (a < b) ? 32'd1 : 32'd0;
      4'b1100: return a << b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  // the shared ALU samples its inputs on the falling edge
  always @(negedge Clk) begin
    alu_result <= alu_f(alu_ctrl, alu_in1, alu_in2);
    alu_zero   <= (alu_f(alu_ctrl, alu_in1, alu_in2) == 32'd0);
  end

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / protocol monitor ----------------
  typedef struct {
    bit          id;
    logic [31:0] res;
    bit          zero;
  } exp_t;

  exp_t exp_q[$];
  exp_t ef;
  bit   last_id = 1'b1;
  int   age = 0;
  bit   outst, e0, e1;
  bit   acc0 = 1'b0, acc1 = 1'b0;

  always @(negedge Clk) begin
    if (!Rst_n) begin
      exp_q.delete();
      last_id = 1'b1;
      age = 0;
    end else begin
      outst = (exp_q.size() != 0);
      if (outst) age++;
      chk(busy == outst, "mon busy", busy, outst);
      chk(rsp_valid == (outst && age >= 2), "mon rsp_valid", rsp_valid, outst && age >= 2);
      e0 = !outst && req0_valid && (!req1_valid || last_id == 1'b1);
      e1 = !outst && req1_valid && (!req0_valid || last_id == 1'b0);
      chk(req0_ready == e0, "mon req0_ready", req0_ready, e0);
      chk(req1_ready == e1, "mon req1_ready", req1_ready, e1);
      if (rsp_valid && outst) begin
        ef = exp_q[0];
        chk(rsp_id == ef.id, "mon rsp_id", rsp_id, ef.id);
        chk(rsp_result == ef.res, "mon rsp_result", rsp_result, ef.res);
        chk(rsp_zero == ef.zero, "mon rsp_zero", rsp_zero, ef.zero);
        if (rsp_ready) void'(exp_q.pop_front());
      end
      if (e0) begin
        ef.id = 1'b0; ef.res = alu_f(req0_ctrl, req0_in1, req0_in2); ef.zero = (ef.res == 0);
        exp_q.push_back(ef); last_id = 1'b0; age = 0;
      end else if (e1) begin
        ef.id = 1'b1; ef.res = alu_f(req1_ctrl, req1_in1, req1_in2); ef.zero = (ef.res == 0);
        exp_q.push_back(ef); last_id = 1'b1; age = 0;
      end
      if (req0_valid && req0_ready) acc0 = 1'b1;
      if (req1_valid && req1_ready) acc1 = 1'b1;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    bit          id;
    logic [3:0]  ctrl;
    logic [31:0] in1, in2;
    logic [31:0] exp_res;
    bit          exp_zero;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_in1 = 0; req0_in2 = 0; req0_ctrl = 0;
    req1_in1 = 0; req1_in2 = 0; req1_ctrl = 0;
  endtask

  task automatic drain();
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (6) tick();
  endtask

  task automatic pulse_reset();
    Rst_n = 0;
    repeat (2) tick();
    Rst_n = 1;
    tick();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit got;
    if (v.id) begin
      req1_valid = 1; req1_in1 = v.in1; req1_in2 = v.in2; req1_ctrl = v.ctrl;
    end else begin
      req0_valid = 1; req0_in1 = v.in1; req0_in2 = v.in2; req0_ctrl = v.ctrl;
    end
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge Clk);
      got = v.id ? req1_ready : req0_ready;
    end
    chk(got, $sformatf("vec%0d accept", idx), got, 1);
    tick();
    req0_valid = 0; req1_valid = 0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge Clk);
      got = rsp_valid;
    end
    chk(got, $sformatf("vec%0d rsp timeout", idx), got, 1);
    chk(rsp_result == v.exp_res, $sformatf("vec%0d result", idx), rsp_result, v.exp_res);
    chk(rsp_zero == v.exp_zero, $sformatf("vec%0d zero", idx), rsp_zero, v.exp_zero);
    chk(rsp_id == v.id, $sformatf("vec%0d id", idx), rsp_id, v.id);
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk(alu_in1 == 0 && alu_in2 == 0 && alu_ctrl == 0, {tag, " alu_*"}, alu_in1 | alu_in2 | alu_ctrl, 0);
    chk(rsp_result == 0 && rsp_zero == 0 && rsp_id == 0, {tag, " rsp_*"}, rsp_result | rsp_zero | rsp_id, 0);
    chk(rsp_valid == 0 && busy == 0, {tag, " valid/busy"}, {rsp_valid, busy}, 0);
    chk(req0_ready == 0 && req1_ready == 0, {tag, " readies"}, {req0_ready, req1_ready}, 0);
  endtask

  logic [3:0] codes[8];
  bit         rid[4];
  logic [31:0] rres[4];
  bit          rzero[4];
  int          nr;
  bit          drop0, drop1, got;
  logic [31:0] hold_res;

  initial begin
    vecs[0]  = '{0, 4'b0010, 32'd5,        32'd7,  32'd12,       0};
    vecs[1]  = '{1, 4'b0110, 32'd9,        32'd9,  32'd0,        1};
    vecs[2]  = '{0, 4'b0001, 32'd1,        32'd2,  32'd3,        0};
    vecs[3]  = '{1, 4'b0000, 32'hFF,       32'h0F, 32'h0F,       0};
    vecs[4]  = '{0, 4'b1111, 32'd3,        32'd4,  32'd0,        1};
    vecs[5]  = '{1, 4'b1100, 32'd1,        32'd4,  32'd16,       0};
    vecs[6]  = '{0, 4'b0111, 32'd2,        32'd3,  32'd1,        0};
    vecs[7]  = '{1, 4'b0111, 32'd3,        32'd2,  32'd0,        1};
    vecs[8]  = '{0, 4'b0111, 32'hFFFFFFFF, 32'd1,  32'd0,        1};
    vecs[9]  = '{1, 4'b0010, 32'hFFFFFFFF, 32'd1,  32'd0,        1};
    vecs[10] = '{0, 4'b0110, 32'd0,        32'd1,  32'hFFFFFFFF, 0};
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1111, 4'b0011};

    idle_inputs();
    rsp_ready = 0;
    Rst_n = 1;
    #2 Rst_n = 0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk_all_zero("reset");
    #2 Rst_n = 1;
    tick();

    // single ADD from req0, rsp_ready tied high
    rsp_ready = 1;
    req0_valid = 1; req0_in1 = 5; req0_in2 = 7; req0_ctrl = 4'b0010;
    @(negedge Clk);
    chk(req0_ready == 1, "t1 ready cycle0", req0_ready, 1);
    tick();
    req0_valid = 0;
    @(negedge Clk);
    chk(rsp_valid == 0, "t1 rsp cycle1", rsp_valid, 0);
    @(negedge Clk);
    chk(rsp_valid == 1, "t1 rsp cycle2", rsp_valid, 1);
    chk(rsp_result == 12 && rsp_zero == 0 && rsp_id == 0, "t1 payload", rsp_result, 12);
    tick();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // simultaneous SUB 9,9 on req0 and OR 1,2 on req1 right after reset
    pulse_reset();
    req0_valid = 1; req0_in1 = 9; req0_in2 = 9; req0_ctrl = 4'b0110;
    req1_valid = 1; req1_in1 = 1; req1_in2 = 2; req1_ctrl = 4'b0001;
    nr = 0;
    for (int k = 0; k < 30 && nr < 2; k++) begin
      @(negedge Clk);
      drop0 = req0_ready; drop1 = req1_ready;
      if (rsp_valid && rsp_ready) begin
        rid[nr] = rsp_id; rres[nr] = rsp_result; rzero[nr] = rsp_zero; nr++;
      end
      tick();
      if (drop0) req0_valid = 0;
      if (drop1) req1_valid = 0;
    end
    chk(nr == 2, "tie responses", nr, 2);
    chk(rid[0] == 0 && rres[0] == 0 && rzero[0] == 1, "tie first", {rid[0], rres[0][3:0], rzero[0]}, 6'b0_0000_1);
    chk(rid[1] == 1 && rres[1] == 3, "tie second", {rid[1], rres[1][3:0]}, 5'b1_0011);
    drain();

    // both valid continuously: grant alternates
    pulse_reset();
    req0_valid = 1; req0_in1 = 10; req0_in2 = 1; req0_ctrl = 4'b0010;
    req1_valid = 1; req1_in1 = 20; req1_in2 = 2; req1_ctrl = 4'b0010;
    nr = 0;
    for (int k = 0; k < 40 && nr < 4; k++) begin
      @(negedge Clk);
      if (rsp_valid && rsp_ready) begin rid[nr] = rsp_id; nr++; end
    end
    chk(nr == 4, "alt count", nr, 4);
    chk({rid[0], rid[1], rid[2], rid[3]} == 4'b0101, "alt order",
        {rid[0], rid[1], rid[2], rid[3]}, 4'b0101);
    tick();
    drain();

    // consumer back-pressure for 5 cycles while req1 waits
    rsp_ready = 0;
    req0_valid = 1; req0_in1 = 1; req0_in2 = 1; req0_ctrl = 4'b0010;
    @(negedge Clk);
    tick();
    req0_valid = 0;
    req1_valid = 1; req1_in1 = 4; req1_in2 = 8; req1_ctrl = 4'b0001;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge Clk);
      got = rsp_valid;
    end
    chk(got, "bp rsp timeout", got, 1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge Clk);
      chk(rsp_valid == 1 && rsp_result == 2 && rsp_id == 0, $sformatf("bp hold%0d", k), rsp_result, 2);
      chk(req1_ready == 0 && req0_ready == 0, $sformatf("bp noready%0d", k), {req0_ready, req1_ready}, 0);
    end
    tick();
    rsp_ready = 1;
    @(negedge Clk);
    @(negedge Clk);
    chk(req1_ready == 1, "bp accept after release", req1_ready, 1);
    tick();
    drain();

    // reset while an AND FF,0F is in ISSUE
    req0_valid = 1; req0_in1 = 32'hFF; req0_in2 = 32'h0F; req0_ctrl = 4'b0000;
    @(negedge Clk);
    chk(req0_ready == 1, "rst accept", req0_ready, 1);
    tick();
    req1_valid = 1; req1_in1 = 7; req1_in2 = 7; req1_ctrl = 4'b0001;
    Rst_n = 0;
    #2;
    chk_all_zero("midrst");
    repeat (2) tick();
    Rst_n = 1;
    @(negedge Clk);
    chk(rsp_valid == 0, "midrst no rsp", rsp_valid, 0);
    chk(req0_ready == 1 && req1_ready == 0, "midrst tie req0", {req0_ready, req1_ready}, 2'b10);
    tick();
    drain();

    // randomized traffic
    acc0 = 0; acc1 = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (acc0) begin acc0 = 0; req0_valid = 0; end
      if (acc1) begin acc1 = 0; req1_valid = 0; end
      if (!req0_valid && $urandom_range(0, 2) != 0) begin
        req0_valid = 1;
        req0_ctrl = codes[$urandom_range(0, 7)];
        req0_in1 = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
        req0_in2 = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
      end
      if (!req1_valid && $urandom_range(0, 2) != 0) begin
        req1_valid = 1;
        req1_ctrl = codes[$urandom_range(0, 7)];
        req1_in1 = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
        req1_in2 = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    drain();
    @(negedge Clk);
    chk(exp_q.size() == 0, "final drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
